// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: x16 oversample strobe plus bit-rate strobe,
// with divisor updates deferred to the next bit boundary.
module uart_baud_gen #(
   parameter int DIV_INT_W      = 16,
   parameter int DIV_FRAC_W     = 4,
   parameter int OVERSAMPLE     = 16,
   parameter int RESET_DIV_INT  = 27,
   parameter int RESET_DIV_FRAC = 2
) (
   input  logic                          uart_clk,
   input  logic                          uart_rst,
   input  logic                          enable,
   input  logic [DIV_INT_W-1:0]          div_int,
   input  logic [DIV_FRAC_W-1:0]         div_frac,
   input  logic                          div_load,
   output logic                          div_pending,
   output logic                          baud_tick_x16,
   output logic                          baud_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] tick_phase
);

   localparam int PW = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0]         LAST     = PW'(OVERSAMPLE - 1);
   localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(RESET_DIV_INT);
   localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(RESET_DIV_FRAC);
   localparam logic [DIV_INT_W-1:0]  RST_CNT  =
      DIV_INT_W'(((RESET_DIV_INT == 0) ? 1 : RESET_DIV_INT) - 1);
   localparam logic [DIV_INT_W-1:0]  ONE      = DIV_INT_W'(1);

   logic [DIV_INT_W-1:0]  act_int, shadow_int, nxt_int;
   logic [DIV_FRAC_W-1:0] act_frac, shadow_frac, nxt_frac;
   logic [DIV_INT_W-1:0]  n_act, n_nxt, cnt, carry_ext;
   logic [DIV_FRAC_W-1:0] acc;
   logic [DIV_FRAC_W:0]   sum;
   logic [PW-1:0]         phase;
   logic                  at_bound, apply, change;

   // Load protocol: div_load is a one-cycle pulse with div_int/div_frac valid
   // in the same cycle; there is no back-pressure, the last load before an
   // apply point wins, and a load in the apply cycle itself bypasses the shadow.
   always_comb begin
      nxt_int   = div_load ? div_int  : (div_pending ? shadow_int  : act_int);
      nxt_frac  = div_load ? div_frac : (div_pending ? shadow_frac : act_frac);
      n_act     = (act_int == '0) ? ONE : act_int;
      n_nxt     = (nxt_int == '0) ? ONE : nxt_int;
      sum       = {1'b0, acc} + {1'b0, act_frac};
      carry_ext = {{(DIV_INT_W-1){1'b0}}, sum[DIV_FRAC_W]};
      at_bound  = (cnt == '0) && (phase == LAST);
      apply     = !enable || at_bound;
      change    = div_load || div_pending;
   end

   always_ff @(posedge uart_clk) begin
      if (uart_rst) begin
         act_int       <= RST_INT;
         act_frac      <= RST_FRAC;
         shadow_int    <= '0;
         shadow_frac   <= '0;
         div_pending   <= 1'b0;
         cnt           <= RST_CNT;
         acc           <= '0;
         phase         <= '0;
         baud_tick_x16 <= 1'b0;
         baud_tick     <= 1'b0;
      end else begin
         baud_tick_x16 <= 1'b0;
         baud_tick     <= 1'b0;
         if (div_load && !apply) begin
            shadow_int  <= div_int;
            shadow_frac <= div_frac;
            div_pending <= 1'b1;
         end
         if (!enable) begin
            act_int     <= nxt_int;
            act_frac    <= nxt_frac;
            div_pending <= 1'b0;
            cnt         <= n_nxt - ONE;
            acc         <= '0;
            phase       <= '0;
         end else if (cnt != '0) begin
            cnt <= cnt - ONE;
         end else begin
            baud_tick_x16 <= 1'b1;
            baud_tick     <= (phase == LAST);
            phase         <= phase + PW'(1);
            // Bit boundary with a new divisor: restart the bit cleanly on it.
            if (at_bound && change) begin
               act_int     <= nxt_int;
               act_frac    <= nxt_frac;
               div_pending <= 1'b0;
               cnt         <= n_nxt - ONE;
               acc         <= '0;
               phase       <= '0;
            end else begin
               acc <= sum[DIV_FRAC_W-1:0];
               cnt <= n_act - ONE + carry_ext;
            end
         end
      end
   end

   assign tick_phase = phase;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: strobe spacing, fractional averaging,
// deferred divisor loads, enable gating and reset.
module tb_uart_baud_gen;

   logic        uart_clk = 1'b0;
   logic        uart_rst = 1'b1;
   logic        enable   = 1'b0;
   logic [15:0] div_int  = '0;
   logic [3:0]  div_frac = '0;
   logic        div_load = 1'b0;
   logic        div_pending, baud_tick_x16, baud_tick;
   logic [3:0]  tick_phase;

   int checks   = 0;
   int failures = 0;

   uart_baud_gen dut (
      .uart_clk      (uart_clk),
      .uart_rst      (uart_rst),
      .enable        (enable),
      .div_int       (div_int),
      .div_frac      (div_frac),
      .div_load      (div_load),
      .div_pending   (div_pending),
      .baud_tick_x16 (baud_tick_x16),
      .baud_tick     (baud_tick),
      .tick_phase    (tick_phase)
   );

   always #5 uart_clk = ~uart_clk;

   task automatic step();
      @(posedge uart_clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Steps until the x16 strobe is seen; n is the number of cycles taken.
   task automatic wait_x16(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!baud_tick_x16 && n < 200);
      if (!baud_tick_x16) chk("x16_timeout", 0, 1);
   endtask

   task automatic load_disabled(input int di, input int df);
      enable = 1'b0;
      step();
      div_int  = 16'(di);
      div_frac = 4'(df);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   initial begin
      int n, sum_a, sum_b;

      // Reset state
      repeat (3) step();
      chk("rst_x16", baud_tick_x16, 0);
      chk("rst_tick", baud_tick, 0);
      chk("rst_pending", div_pending, 0);
      chk("rst_phase", tick_phase, 0);
      uart_rst = 1'b0;
      step();

      // Default divisor 27 + 2/16
      enable = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         wait_x16(n);
         chk("t1_interval", n, (i == 1) ? 27 : 27 + (((i - 1) % 8 == 0) ? 1 : 0));
         chk("t1_tick", baud_tick, (i == 16) ? 1 : 0);
         chk("t1_phase", tick_phase, i % 16);
      end

      // Integer divisor 4 loaded while disabled
      load_disabled(4, 0);
      chk("t2_pending", div_pending, 0);
      chk("t2_x16_off", baud_tick_x16, 0);
      enable = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         wait_x16(n);
         chk("t2_interval", n, 4);
         chk("t2_tick", baud_tick, (i % 16 == 0) ? 1 : 0);
      end

      // Fractional divisor 4 + 8/16
      load_disabled(4, 8);
      enable = 1'b1;
      sum_a = 0;
      sum_b = 0;
      for (int i = 1; i <= 32; i++) begin
         wait_x16(n);
         chk("t3_interval", n, (i == 1) ? 4 : 4 + (((i - 1) % 2 == 0) ? 1 : 0));
         chk("t3_tick", baud_tick, (i % 16 == 0) ? 1 : 0);
         if (i <= 16) sum_a += n;
         else sum_b += n;
      end
      chk("t3_first_bit", sum_a, 71);
      chk("t3_bit_period", sum_b, 72);

      // Mid-bit load is deferred to the next baud_tick
      load_disabled(4, 0);
      enable = 1'b1;
      for (int i = 1; i <= 5; i++) wait_x16(n);
      chk("t4_phase5", tick_phase, 5);
      div_int  = 16'd8;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      chk("t4_pending_set", div_pending, 1);
      for (int i = 6; i <= 16; i++) begin
         wait_x16(n);
         chk("t4_old_interval", (i == 6) ? n + 1 : n, 4);
         if (i == 15) chk("t4_pending_hold", div_pending, 1);
      end
      chk("t4_tick", baud_tick, 1);
      chk("t4_pending_clr", div_pending, 0);
      chk("t4_phase0", tick_phase, 0);
      for (int i = 17; i <= 19; i++) begin
         wait_x16(n);
         chk("t4_new_interval", n, 8);
      end

      // Two loads before the boundary: last one wins
      div_int  = 16'd6;
      div_load = 1'b1;
      step();
      div_int  = 16'd10;
      step();
      div_load = 1'b0;
      chk("t5_pending", div_pending, 1);
      for (int i = 20; i <= 32; i++) begin
         wait_x16(n);
         chk("t5_old_interval", (i == 20) ? n + 2 : n, 8);
      end
      chk("t5_tick", baud_tick, 1);
      chk("t5_pending_clr", div_pending, 0);
      for (int i = 33; i <= 47; i++) begin
         wait_x16(n);
         chk("t5_new_interval", n, 10);
      end
      chk("t5_phase15", tick_phase, 15);

      // Load in the cycle whose edge produces baud_tick
      repeat (9) step();
      chk("t5_pre_x16", baud_tick_x16, 0);
      div_int  = 16'd5;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      chk("t5_coin_tick", baud_tick, 1);
      chk("t5_coin_pending", div_pending, 0);
      step();
      chk("t5_coin_pending2", div_pending, 0);
      wait_x16(n);
      chk("t5_coin_interval", n + 1, 5);

      // Reset discards a pending load and restores the default divisor
      div_int  = 16'd9;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      chk("t6_pending_set", div_pending, 1);
      uart_rst = 1'b1;
      enable   = 1'b0;
      step();
      chk("t6_rst_pending", div_pending, 0);
      chk("t6_rst_x16", baud_tick_x16, 0);
      uart_rst = 1'b0;
      step();
      enable = 1'b1;
      wait_x16(n);
      chk("t6_rst_first", n, 27);

      // div_int=0 acts as 1; enable drop mid-bit
      load_disabled(0, 0);
      enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wait_x16(n);
         chk("t6_zero_interval", n, 1);
         chk("t6_zero_phase", tick_phase, i);
      end
      enable = 1'b0;
      step();
      chk("t6_off_x16", baud_tick_x16, 0);
      chk("t6_off_tick", baud_tick, 0);
      chk("t6_off_phase", tick_phase, 0);
      step();
      chk("t6_off_x16_2", baud_tick_x16, 0);
      enable = 1'b1;
      wait_x16(n);
      chk("t6_reen_first", n, 1);
      chk("t6_reen_phase", tick_phase, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
